// File: rtl/udp_rx.sv
// UDP receive parser: strips the 8-byte UDP header, filters on destination port,
// and packs payload bytes big-endian into 16-bit FIFO words with done/error status.
module udp_rx #(
    parameter bit          CHECK_PORT  = 1'b1,
    parameter int unsigned MAX_PAYLOAD = 1472
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] local_udp_port,
    input  logic        udp_rx_start,
    input  logic        udp_rx_valid,
    input  logic [7:0]  udp_rx_data,
    input  logic        udp_rx_end,
    output logic        fifo_wr_en,
    output logic [15:0] fifo_wr_data,
    output logic [15:0] rx_source_port,
    output logic [15:0] rx_destination_port,
    output logic [15:0] rx_data_length,
    output logic        udp_rx_done,
    output logic        udp_rx_error,
    output logic        udp_rx_busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HEADER = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PAD    = 3'd3;
    localparam logic [2:0] S_DROP   = 3'd4;

    localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD + 8);

    logic [2:0]  state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] src, src_n, dst, dst_n, len, len_n;
    logic [7:0]  hi, hi_n;
    logic        wr_n, done_n, err_n;
    logic [15:0] wdata_n;
    logic [15:0] len_field;

    assign len_field   = {len[15:8], udp_rx_data};
    assign udp_rx_busy = (state != S_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        src_n   = src;
        dst_n   = dst;
        len_n   = len;
        hi_n    = hi;
        wr_n    = 1'b0;
        wdata_n = fifo_wr_data;
        done_n  = 1'b0;
        err_n   = 1'b0;
        if (udp_rx_start) begin
            // A new datagram aborts whatever was in flight; only an unfinished parse is an error.
            err_n   = (state == S_HEADER) || (state == S_DATA);
            state_n = S_HEADER;
            cnt_n   = 16'd0;
            if (udp_rx_valid) begin
                src_n[15:8] = udp_rx_data;
                cnt_n       = 16'd1;
            end
        end else begin
            if (udp_rx_valid && state != S_IDLE)
                cnt_n = cnt + 16'd1;
            case (state)
                S_HEADER: if (udp_rx_valid) begin
                    case (cnt[2:0])
                        3'd0: src_n[15:8] = udp_rx_data;
                        3'd1: src_n[7:0]  = udp_rx_data;
                        3'd2: dst_n[15:8] = udp_rx_data;
                        3'd3: begin
                            dst_n[7:0] = udp_rx_data;
                            if (CHECK_PORT && ({dst[15:8], udp_rx_data} != local_udp_port))
                                state_n = S_DROP;
                        end
                        3'd4: len_n[15:8] = udp_rx_data;
                        3'd5: begin
                            len_n[7:0] = udp_rx_data;
                            if (len_field < 16'd8 || len_field > MAX_LEN) begin
                                err_n   = 1'b1;
                                state_n = S_DROP;
                            end
                        end
                        3'd7: begin
                            if (len == 16'd8) begin
                                done_n  = 1'b1;
                                state_n = S_PAD;
                            end else begin
                                state_n = S_DATA;
                            end
                        end
                        default: ; // checksum high byte ignored
                    endcase
                end
                S_DATA: if (udp_rx_valid) begin
                    // Header is 8 bytes, so even cnt means even payload index.
                    if (!cnt[0]) begin
                        hi_n = udp_rx_data;
                    end else begin
                        wr_n    = 1'b1;
                        wdata_n = {hi, udp_rx_data};
                    end
                    if (cnt == len - 16'd1) begin
                        if (!cnt[0]) begin
                            wr_n    = 1'b1;
                            wdata_n = {udp_rx_data, 8'h00};
                        end
                        done_n  = 1'b1;
                        state_n = S_PAD;
                    end
                end
                default: ;
            endcase
            if (udp_rx_end && state != S_IDLE) begin
                if (state_n == S_HEADER || state_n == S_DATA)
                    err_n = 1'b1;
                state_n = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_IDLE;
            cnt                 <= 16'd0;
            src                 <= 16'd0;
            dst                 <= 16'd0;
            len                 <= 16'd0;
            hi                  <= 8'd0;
            fifo_wr_en          <= 1'b0;
            fifo_wr_data        <= 16'd0;
            udp_rx_done         <= 1'b0;
            udp_rx_error        <= 1'b0;
            rx_source_port      <= 16'd0;
            rx_destination_port <= 16'd0;
            rx_data_length      <= 16'd0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            src          <= src_n;
            dst          <= dst_n;
            len          <= len_n;
            hi           <= hi_n;
            fifo_wr_en   <= wr_n;
            fifo_wr_data <= wdata_n;
            udp_rx_done  <= done_n;
            udp_rx_error <= err_n;
            // Header fields are final well before completion, so the latched copies are safe here.
            if (done_n) begin
                rx_source_port      <= src;
                rx_destination_port <= dst;
                rx_data_length      <= len - 16'd8;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx.sv
// Bench for udp_rx: directed vectors, timing sequences and random datagrams
// checked against a byte-list model of the datagram rules.
module tb_udp_rx;

    localparam logic [15:0] LP = 16'h1F90;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] local_udp_port = LP;
    logic        udp_rx_start = 1'b0;
    logic        udp_rx_valid = 1'b0;
    logic [7:0]  udp_rx_data = 8'h00;
    logic        udp_rx_end = 1'b0;
    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic [15:0] rx_source_port, rx_destination_port, rx_data_length;
    logic        udp_rx_done, udp_rx_error, udp_rx_busy;

    udp_rx dut (
        .clk(clk), .rst_n(rst_n), .local_udp_port(local_udp_port),
        .udp_rx_start(udp_rx_start), .udp_rx_valid(udp_rx_valid),
        .udp_rx_data(udp_rx_data), .udp_rx_end(udp_rx_end),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .rx_source_port(rx_source_port), .rx_destination_port(rx_destination_port),
        .rx_data_length(rx_data_length), .udp_rx_done(udp_rx_done),
        .udp_rx_error(udp_rx_error), .udp_rx_busy(udp_rx_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic s; logic v; logic e; logic [7:0] d;} cyc_t;
    typedef struct {logic [15:0] dst; logic [15:0] len; int nsend; int ew; int ed; int ee;} vec_t;

    cyc_t        stim[$];
    logic [7:0]  fixp[$];
    logic [7:0]  pl[$];
    logic [15:0] got_w[$], exp_w[$];
    int          acc_cyc[$], wr_cyc[$], done_cyc[$], err_cyc[$];
    int          cyc = 0;
    int          n_nowr = 0, n_excl = 0, exp_done = 0, exp_err = 0, exp_nowr = 0;
    logic [15:0] m_src = 16'd0, m_dst = 16'd0, m_len = 16'd0;
    int          tests = 0, fails = 0;
    vec_t        tbl[8];

    always @(posedge clk) cyc++;

    always @(negedge clk) if (rst_n) begin
        if (fifo_wr_en) begin
            got_w.push_back(fifo_wr_data);
            wr_cyc.push_back(cyc);
        end
        if (udp_rx_done) begin
            done_cyc.push_back(cyc);
            if (!fifo_wr_en) n_nowr++;
        end
        if (udp_rx_error) err_cyc.push_back(cyc);
        if (udp_rx_done && udp_rx_error) n_excl++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Header, then nsend bytes (fixed payload first, random after), optional gaps and end.
    task automatic gen(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                       input int nsend, input bit with_end, input int gap_pct);
        logic [7:0] hdr [8];
        logic [7:0] b;
        int total;
        bit esep;
        hdr = '{src[15:8], src[7:0], dst[15:8], dst[7:0], len[15:8], len[7:0], 8'h00, 8'h00};
        total = 8 + nsend;
        esep = with_end && ($urandom_range(1) == 1);
        pl.delete();
        for (int i = 0; i < total; i++) begin
            if (i > 0 && int'($urandom_range(99)) < gap_pct)
                stim.push_back('{s: 1'b0, v: 1'b0, e: 1'b0, d: 8'h00});
            if (i < 8) b = hdr[i];
            else if (i - 8 < fixp.size()) b = fixp[i - 8];
            else b = 8'($urandom);
            if (i >= 8) pl.push_back(b);
            stim.push_back('{s: (i == 0), v: 1'b1, e: (with_end && !esep && i == total - 1), d: b});
        end
        if (esep) stim.push_back('{s: 1'b0, v: 1'b0, e: 1'b1, d: 8'h00});
    endtask

    // Expected outcome of the datagram just generated, from the byte list in pl.
    task automatic model(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                         input int nsend);
        int p;
        if (dst != LP) return;
        if (len < 16'd8 || len > 16'd1480) begin
            exp_err++;
            return;
        end
        p = int'(len) - 8;
        if (nsend >= p) begin
            for (int j = 0; j < p; j += 2)
                exp_w.push_back({pl[j], (j + 1 < p) ? pl[j + 1] : 8'h00});
            exp_done++;
            if (p == 0) exp_nowr++;
            m_src = src;
            m_dst = dst;
            m_len = 16'(p);
        end else begin
            for (int j = 0; j + 1 < nsend; j += 2)
                exp_w.push_back({pl[j], pl[j + 1]});
            exp_err++;
        end
    endtask

    task automatic dg(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                      input int nsend, input bit with_end, input int gap_pct);
        gen(src, dst, len, nsend, with_end, gap_pct);
        model(src, dst, len, nsend);
    endtask

    task automatic play();
        foreach (stim[i]) begin
            @(negedge clk);
            udp_rx_start = stim[i].s;
            udp_rx_valid = stim[i].v;
            udp_rx_end   = stim[i].e;
            udp_rx_data  = stim[i].d;
            if (stim[i].v) acc_cyc.push_back(cyc + 1);
        end
        @(negedge clk);
        udp_rx_start = 1'b0;
        udp_rx_valid = 1'b0;
        udp_rx_end   = 1'b0;
        udp_rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        stim.delete();
    endtask

    task automatic check_group();
        int n;
        chk("word_count", got_w.size(), exp_w.size());
        n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) chk("word_data", got_w[i], exp_w[i]);
        chk("done_count", done_cyc.size(), exp_done);
        chk("error_count", err_cyc.size(), exp_err);
        chk("done_without_write", n_nowr, exp_nowr);
        chk("done_error_overlap", n_excl, 0);
        chk("rx_source_port", rx_source_port, m_src);
        chk("rx_destination_port", rx_destination_port, m_dst);
        chk("rx_data_length", rx_data_length, m_len);
        chk("busy_idle", udp_rx_busy, 1'b0);
        got_w.delete(); exp_w.delete(); acc_cyc.delete(); wr_cyc.delete();
        done_cyc.delete(); err_cyc.delete(); fixp.delete();
        n_nowr = 0; n_excl = 0; exp_done = 0; exp_err = 0; exp_nowr = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"}, fifo_wr_en, 1'b0);
        chk({tag, "_wr_data"}, fifo_wr_data, 16'h0);
        chk({tag, "_src"}, rx_source_port, 16'h0);
        chk({tag, "_dst"}, rx_destination_port, 16'h0);
        chk({tag, "_len"}, rx_data_length, 16'h0);
        chk({tag, "_done"}, udp_rx_done, 1'b0);
        chk({tag, "_error"}, udp_rx_error, 1'b0);
        chk({tag, "_busy"}, udp_rx_busy, 1'b0);
    endtask

    initial begin
        tbl[0] = '{LP,       16'h000C, 4,    2,   1, 0};
        tbl[1] = '{LP,       16'h000B, 18,   2,   1, 0};
        tbl[2] = '{16'h1234, 16'h0014, 12,   0,   0, 0};
        tbl[3] = '{LP,       16'h0004, 4,    0,   0, 1};
        tbl[4] = '{LP,       16'h05C9, 4,    0,   0, 1};
        tbl[5] = '{LP,       16'h0010, 3,    1,   0, 1};
        tbl[6] = '{LP,       16'h0008, 5,    0,   1, 0};
        tbl[7] = '{LP,       16'h05C8, 1472, 736, 1, 0};

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Even payload with exact write and done timing
        fixp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        dg(LP, LP, 16'h000C, 4, 1'b1, 0);
        play();
        chk("even_w0", qat(acc_cyc, 9) == qat(wr_cyc, 0), 1'b1);
        chk("even_w1", qat(acc_cyc, 11) == qat(wr_cyc, 1), 1'b1);
        chk("even_done_t", qat(done_cyc, 0) == qat(wr_cyc, 1), 1'b1);
        chk("even_word0", got_w.size() > 0 ? got_w[0] : 16'hxxxx, 16'hDEAD);
        check_group();

        // Bad length: error pulse one cycle after byte 5
        dg(16'h0007, LP, 16'h0004, 4, 1'b1, 0);
        play();
        chk("badlen_err_t", qat(acc_cyc, 5) == qat(err_cyc, 0), 1'b1);
        check_group();

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            dg(16'h0ABC + 16'(i), tbl[i].dst, tbl[i].len, tbl[i].nsend, 1'b1,
               int'($urandom_range(30)));
            play();
            chk("vec_words", got_w.size(), tbl[i].ew);
            chk("vec_done", done_cyc.size(), tbl[i].ed);
            chk("vec_error", err_cyc.size(), tbl[i].ee);
            check_group();
        end

        // Gapped valid gives the same words
        fixp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        dg(LP, LP, 16'h000C, 4, 1'b1, 50);
        play();
        chk("gap_word1", got_w.size() > 1 ? got_w[1] : 16'hxxxx, 16'hBEEF);
        check_group();

        // Restart in DATA, then a clean datagram
        dg(16'h1111, LP, 16'h0010, 3, 1'b0, 0);
        dg(16'h2222, LP, 16'h000C, 4, 1'b1, 0);
        play();
        chk("restart_err", err_cyc.size(), 1);
        chk("restart_done", done_cyc.size(), 1);
        check_group();

        // Reset mid-DATA
        fixp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        gen(16'h5555, LP, 16'h0014, 5, 1'b0, 0);
        play();
        exp_w.push_back(16'h1122);
        exp_w.push_back(16'h3344);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        m_src = 16'h0; m_dst = 16'h0; m_len = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_group();
        dg(16'h3333, LP, 16'h000D, 5, 1'b1, 0);
        play();
        check_group();

        // Random groups, possibly two back-to-back datagrams with an abort
        for (int g = 0; g < 40; g++) begin
            int nd;
            nd = int'($urandom_range(1, 2));
            for (int d = 0; d < nd; d++) begin
                logic [15:0] dst, len;
                int nsend, p;
                bit good;
                dst = ($urandom_range(9) < 8) ? LP : 16'($urandom);
                case ($urandom_range(9))
                    0:       len = 16'($urandom_range(7));
                    1:       len = 16'(1481 + $urandom_range(50));
                    default: len = 16'(8 + $urandom_range(40));
                endcase
                good = (len >= 16'd8 && len <= 16'd1480);
                p = good ? int'(len) - 8 : 0;
                if (good && p > 0 && $urandom_range(3) == 0)
                    nsend = int'($urandom_range(p - 1));
                else
                    nsend = p + int'($urandom_range(10));
                dg(16'($urandom), dst, len, nsend,
                   (d == nd - 1) ? 1'b1 : 1'($urandom_range(1)), int'($urandom_range(40)));
            end
            play();
            check_group();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/udp_rx.md
Name: udp_rx

Overview:
- UDP receive parser; mirror of the UDP transmit path. Sits between the IP receive layer and the application payload FIFO.
- Consumes the byte stream of one UDP datagram (header plus payload, IP header already stripped), extracts ports and length, and filters on the local destination port.
- Packs payload bytes big-endian into 16-bit words and pushes them into a write-side FIFO.
- Reports completion or error per datagram.

Parameters:
- CHECK_PORT, 1, when 1 drop datagrams whose destination port != local_udp_port.
- MAX_PAYLOAD, 1472, largest accepted UDP payload in bytes.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- local_udp_port  in  16  port this node listens on
- udp_rx_start  in  1  one-cycle pulse marking the first byte of a datagram; may coincide with udp_rx_valid
- udp_rx_valid  in  1  udp_rx_data carries a byte this cycle
- udp_rx_data  in  8  datagram byte, network order
- udp_rx_end  in  1  pulse marking end of IP payload; may coincide with the last valid byte
- fifo_wr_en  out  1  payload FIFO write strobe
- fifo_wr_data  out  16  payload word; first byte in [15:8]
- rx_source_port  out  16  source port of the last accepted datagram
- rx_destination_port  out  16  destination port of the last accepted datagram
- rx_data_length  out  16  payload bytes (UDP length − 8) of the last accepted datagram
- udp_rx_done  out  1  one-cycle pulse: datagram fully received and written
- udp_rx_error  out  1  one-cycle pulse: malformed or truncated datagram
- udp_rx_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; counters and the byte latch cleared. A reset mid-datagram discards the datagram with no done or error pulse.
- Byte acceptance: a byte is taken only when udp_rx_valid=1. Byte counter cnt is 16 bits, starts at 0, and increments per accepted byte.
- States:
  - IDLE to HEADER on udp_rx_start. If udp_rx_valid is high in the same cycle, that byte is cnt 0.
  - HEADER, cnt 0..7: bytes 0-1 are source port, 2-3 destination port, 4-5 length, 6-7 checksum. The checksum is ignored, because our transmitter sends 0.
  - HEADER port check: after byte 3, if CHECK_PORT=1 and the port != local_udp_port, go to DROP with no error pulse.
  - HEADER length check: after byte 5, if length < 8 or length > MAX_PAYLOAD+8, pulse udp_rx_error and go to DROP.
  - HEADER exit: after byte 7, if length == 8, pulse udp_rx_done and go to PAD; otherwise go to DATA.
  - DATA: for payload index p (0-based), an even p latches the high byte and an odd p writes {hi, byte}.
  - DATA final byte: on the last payload byte (p == length−9), go to PAD. If p is even (odd payload count), write {byte, 8'h00}.
  - PAD: discard bytes (Ethernet minimum-frame padding) until udp_rx_end, then go to IDLE.
  - DROP: discard bytes until udp_rx_end, then go to IDLE.
- Write timing: fifo_wr_en/fifo_wr_data are registered and assert exactly 1 cycle after the accepting byte cycle. fifo_wr_en is a single-cycle pulse per word. Words = ceil(payload/2).
- Done timing: udp_rx_done asserts in the same cycle as the final fifo_wr_en.
- Status capture: rx_source_port, rx_destination_port and rx_data_length update only when a datagram completes, on the cycle udp_rx_done asserts. Otherwise they hold.
- Truncation: udp_rx_end in HEADER or DATA before completion pulses udp_rx_error, then go to IDLE. Words already written stay in the FIFO.
- End on the last byte: udp_rx_end coinciding with the last payload byte is a normal completion. It gives done with no error, and the next state is IDLE.
- Restart: udp_rx_start while not IDLE aborts and restarts at HEADER. Pulse udp_rx_error if the abort happens in HEADER or DATA; no pulse if in PAD or DROP.
- Port capture: during HEADER the parser latches ports into internal registers, not the outputs.
- Back-pressure: there is none. The FIFO is sized so it never fills.
- Error/done exclusivity: udp_rx_error and udp_rx_done are never high together.

Test Plan:
- Even payload: local_udp_port=0x1F90; datagram 1F90→1F90, length 0x000C, payload DE AD BE EF → writes 0xDEAD then 0xBEEF, one cycle after bytes 9 and 11; done with the second write; rx_data_length=4.
- Odd payload with padding: length 0x000B, payload 11 22 33, then 15 pad bytes, then end → words 0x1122, 0x3300; done once; pad bytes produce no writes; busy falls after end.
- Port filter: CHECK_PORT=1, destination port 0x1234 ≠ 0x1F90, 20-byte datagram → no fifo_wr_en, no done, no error; status outputs unchanged.
- Bad length: length 0x0004 → error pulse after byte 5; no writes. Length 0x05C9 with MAX_PAYLOAD=1472 → error.
- Truncation and restart: length 0x0010, udp_rx_end after 3 payload bytes → one write 0x(b0b1), error pulse, no done. Separately, udp_rx_start in DATA → error, then the new datagram parses correctly.
- Gapped valid and reset: udp_rx_valid toggled 1-0-1 through a 4-byte payload → identical words. rst_n low mid-DATA → all outputs 0 and state IDLE immediately; the next datagram is received normally.
